logo_motion_ctrl: RTL
=====================

# logo_motion_ctrl

Frame-synchronous motion controller for the bouncing bitmap logo. Once per frame it sequences the logo's top-left position: it reflects the logo off the screen edges in bounce mode, or moves it under gamepad control in manual mode. It sits between the VGA sync generator (`vpos`), the gamepad decoder and the pixel/ROM addressing path, which consumes `logo_left`/`logo_top`.

## Interface
- `DISPLAY_WIDTH`, 640, visible width in pixels
- `DISPLAY_HEIGHT`, 480, visible height in pixels
- `LOGO_SIZE`, 64, logo edge length in pixels
- `INIT_X`, 200, reset value of `logo_left`
- `INIT_Y`, 200, reset value of `logo_top`
- `STEP`, 1, pixels moved per frame per axis (1..15)

- `clk`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-high reset
- `vpos`  in  10  current scanline from the sync generator
- `btn_start`  in  1  gamepad start, level
- `btn_up` / `btn_down` / `btn_left` / `btn_right`  in  1 each  gamepad directions, level
- `logo_left`  out  10  logo X origin, registered
- `logo_top`  out  10  logo Y origin, registered
- `manual_mode`  out  1  1 = manual, 0 = bounce
- `update_done`  out  1  one-cycle pulse after each frame update
- `bounce_count`  out  8  wall-reflection counter (see Configuration)

## Operation
- Limits: `XMAX = DISPLAY_WIDTH-LOGO_SIZE` (576) and `YMAX = DISPLAY_HEIGHT-LOGO_SIZE` (416). Positions always stay in [0, XMAX] / [0, YMAX].
- Arithmetic: 11-bit internally, so that `pos-STEP` below 0 is detected rather than wrapped.
- Frame tick: `prev_vpos` is registered every cycle. `tick = (vpos==0) && (prev_vpos!=0)`.
- FSM states:
  - IDLE: on `tick`, latch all five buttons and go to MOVE_X.
  - MOVE_X, then MOVE_Y: one cycle each.
  - COMMIT: one cycle, then back to IDLE.
- Bounce mode, X axis (the Y axis is identical, using up/down/`dir_y`/YMAX):
  - Direction override first. `btn_left` sets dir_x=0; else `btn_right` sets dir_x=1. Left wins when both are pressed.
  - Moving with dir_x=1: if `left+STEP >= XMAX`, set left=XMAX, dir_x=0 and count a reflection. Otherwise left += STEP.
  - Moving with dir_x=0: if `left <= STEP`, set left=0, dir_x=1 and count a reflection. Otherwise left -= STEP.
- Manual mode:
  - left only: saturating subtract STEP, floor 0.
  - right only: saturating add STEP, ceiling XMAX.
  - both or neither: hold position. Y axis is the same with up/down.
  - Direction registers and the bounce counter are unchanged.
- COMMIT:
  - A rising edge of the latched start button toggles `manual_mode`. The edge is measured against the start value latched on the previous frame, and that reference then takes the new value.
  - `update_done` is asserted.
- Mode switch: a new mode takes effect from the next frame's update. Bounce resumes with the retained `dir_x`/`dir_y`.
- Reset (asynchronous, any state): FSM to IDLE; `logo_left`=INIT_X, `logo_top`=INIT_Y, dir_x=1, dir_y=0, `manual_mode`=0, `update_done`=0, `bounce_count`=0, `prev_vpos`=0, start reference=0.
- Because `prev_vpos` resets to 0, no tick occurs before the first `vpos` wrap after reset.
- A `tick` arriving outside IDLE is ignored. This cannot occur with real VGA timing.

## Timing
- `tick` is high in cycle T. Buttons are latched at edge T.
- `logo_left` is valid after edge T+1, `logo_top` after edge T+2.
- `manual_mode` is updated and `update_done` rises after edge T+3; `update_done` is high exactly one cycle.
- Total latency from tick to done: 4 cycles, all within scanline 0 (blanking-safe for any `LOGO_SIZE` origin at or below line 1).
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `LOGO_BOUNCE_COUNT_EN` defined:
  - `bounce_count` adds the number of reflections in the frame (0, 1 or 2) at MOVE_Y, wrapping modulo 256.
  - Manual mode never increments it.
- `LOGO_BOUNCE_COUNT_EN` undefined: the counter is not built and `bounce_count` is tied to 0.

## Test plan
- Reset: assert `reset` mid-MOVE_X → `logo_left`=200, `logo_top`=200, `manual_mode`=0, `update_done`=0 immediately, with no clock needed.
- Free bounce, STEP=1, from reset: after 3 frames → left=203, top=197; `update_done` pulses once per frame, 4 cycles after each `vpos` wrap.
- Corner hit, count enabled: preload via frames so left=575, top=1, dir_x=1, dir_y=0; next frame → left=576, top=0, dir_x=0, dir_y=1, `bounce_count` +2.
- Overshoot, STEP=3: left=575, dir_x=1 → left=576 (not 578), dir_x=0.
- Mode toggle: hold `btn_start` for 5 frames → `manual_mode` 0→1 once. Then `btn_left` held for 300 frames from left=200 → left saturates at 0. Both left and right held → no move.
- Start edge across frames: press and release start entirely between two ticks → no toggle. With count undefined, a corner hit leaves `bounce_count`=0.

Source files
------------

// File: rtl/logo_motion_ctrl_if.sv
// Bus between the bouncing-logo motion controller and its neighbours:
// scanline/gamepad inputs in, logo origin and status out.
// The controller uses the slave modport; the sync generator, gamepad
// decoder and pixel path together form the master side.
interface logo_motion_ctrl_if;
    logic [9:0] vpos;
    logic       btn_start;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [9:0] logo_left;
    logic [9:0] logo_top;
    logic       manual_mode;
    logic       update_done;
    logic [7:0] bounce_count;

    modport master (
        output vpos,
        output btn_start,
        output btn_up,
        output btn_down,
        output btn_left,
        output btn_right,
        input  logo_left,
        input  logo_top,
        input  manual_mode,
        input  update_done,
        input  bounce_count
    );

    modport slave (
        input  vpos,
        input  btn_start,
        input  btn_up,
        input  btn_down,
        input  btn_left,
        input  btn_right,
        output logo_left,
        output logo_top,
        output manual_mode,
        output update_done,
        output bounce_count
    );
endinterface

// File: rtl/logo_motion_ctrl.sv
// logo_motion_ctrl: once per frame (on the vpos wrap to 0) moves the
// logo's top-left origin, bouncing off the screen edges or following the
// gamepad in manual mode. Updates take four cycles, all inside scanline 0.
// Optional feature macro: LOGO_BOUNCE_COUNT_EN builds the wall-reflection
// counter; without it bounce_count is tied to 0.
module logo_motion_ctrl #(
    parameter int DISPLAY_WIDTH  = 640,
    parameter int DISPLAY_HEIGHT = 480,
    parameter int LOGO_SIZE      = 64,
    parameter int INIT_X         = 200,
    parameter int INIT_Y         = 200,
    parameter int STEP           = 1
) (
    input logic               clk,
    input logic               reset,
    logo_motion_ctrl_if.slave bus
);

    // 11-bit limits and step so that pos-STEP below zero is visible
    localparam logic [10:0] XMAX     = 11'(DISPLAY_WIDTH - LOGO_SIZE);
    localparam logic [10:0] YMAX     = 11'(DISPLAY_HEIGHT - LOGO_SIZE);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [9:0]  INIT_LEFT = 10'(INIT_X);
    localparam logic [9:0]  INIT_TOP  = 10'(INIT_Y);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_X = 2'd1,
        MOVE_Y = 2'd2,
        COMMIT = 2'd3
    } state_t;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
    } axis_t;

    // Direction after the gamepad override; the negative button wins a tie
    function automatic logic effDir(input logic dir, input logic btnNeg,
                                    input logic btnPos);
        logic d;
        if (btnNeg)      d = 1'b0;
        else if (btnPos) d = 1'b1;
        else             d = dir;
        return d;
    endfunction

    // One axis update: saturating move in manual mode, reflecting move in
    // bounce mode. Direction is left untouched while in manual mode.
    function automatic axis_t axisStep(input logic [9:0]  pos,
                                       input logic        dir,
                                       input logic        btnNeg,
                                       input logic        btnPos,
                                       input logic        manual,
                                       input logic [10:0] lim);
        axis_t       res;
        logic [10:0] wide;
        logic [10:0] sum;
        wide    = {1'b0, pos};
        sum     = wide + STEP_W;
        res.pos = pos;
        res.dir = dir;
        if (manual) begin
            if (btnNeg && !btnPos) begin
                res.pos = (wide <= STEP_W) ? 10'd0 : 10'(wide - STEP_W);
            end else if (btnPos && !btnNeg) begin
                res.pos = (sum >= lim) ? 10'(lim) : 10'(sum);
            end
        end else if (effDir(dir, btnNeg, btnPos)) begin
            if (sum >= lim) begin
                res.pos = 10'(lim);
                res.dir = 1'b0;
            end else begin
                res.pos = 10'(sum);
                res.dir = 1'b1;
            end
        end else begin
            if (wide <= STEP_W) begin
                res.pos = 10'd0;
                res.dir = 1'b1;
            end else begin
                res.pos = 10'(wide - STEP_W);
                res.dir = 1'b0;
            end
        end
        return res;
    endfunction

    state_t     r_state;
    state_t     w_stateNext;
    logic       w_tick;
    logic       w_latch;
    logic       w_moveX;
    logic       w_moveY;
    logic       w_commit;

    logic [9:0] r_prevVpos;
    logic       r_btnStart;
    logic       r_btnUp;
    logic       r_btnDown;
    logic       r_btnLeft;
    logic       r_btnRight;
    logic       r_startRef;

    logic [9:0] r_left;
    logic [9:0] r_top;
    logic       r_dirX;
    logic       r_dirY;
    logic       r_manual;
    logic       r_done;

    axis_t      w_axisX;
    axis_t      w_axisY;

    // Frame tick: first cycle of scanline 0
    assign w_tick = (bus.vpos == 10'd0) && (r_prevVpos != 10'd0);

    // Candidate next positions from the latched buttons and current mode
    assign w_axisX = axisStep(r_left, r_dirX, r_btnLeft, r_btnRight, r_manual, XMAX);
    assign w_axisY = axisStep(r_top, r_dirY, r_btnUp, r_btnDown, r_manual, YMAX);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_stateNext;
    end

    // FSM sequencing: IDLE -> MOVE_X -> MOVE_Y -> COMMIT -> IDLE
    always_comb begin
        w_stateNext = r_state;
        w_latch     = 1'b0;
        w_moveX     = 1'b0;
        w_moveY     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    w_latch     = 1'b1;
                    w_stateNext = MOVE_X;
                end
            end
            MOVE_X: begin
                w_moveX     = 1'b1;
                w_stateNext = MOVE_Y;
            end
            MOVE_Y: begin
                w_moveY     = 1'b1;
                w_stateNext = COMMIT;
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Previous scanline for wrap detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_prevVpos <= 10'd0;
        else       r_prevVpos <= bus.vpos;
    end

    // Snapshot of the gamepad taken at the frame tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btnStart <= 1'b0;
            r_btnUp    <= 1'b0;
            r_btnDown  <= 1'b0;
            r_btnLeft  <= 1'b0;
            r_btnRight <= 1'b0;
        end else if (w_latch) begin
            r_btnStart <= bus.btn_start;
            r_btnUp    <= bus.btn_up;
            r_btnDown  <= bus.btn_down;
            r_btnLeft  <= bus.btn_left;
            r_btnRight <= bus.btn_right;
        end
    end

    // Horizontal position and direction, updated in MOVE_X
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_left <= INIT_LEFT;
            r_dirX <= 1'b1;
        end else if (w_moveX) begin
            r_left <= w_axisX.pos;
            r_dirX <= w_axisX.dir;
        end
    end

    // Vertical position and direction, updated in MOVE_Y
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_top  <= INIT_TOP;
            r_dirY <= 1'b0;
        end else if (w_moveY) begin
            r_top  <= w_axisY.pos;
            r_dirY <= w_axisY.dir;
        end
    end

    // Start-button edge toggles the mode at COMMIT; done pulses one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_manual   <= 1'b0;
            r_startRef <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_manual   <= r_manual ^ (r_btnStart & ~r_startRef);
                r_startRef <= r_btnStart;
            end
        end
    end

`ifdef LOGO_BOUNCE_COUNT_EN
    logic       r_hitX;
    logic       w_hitX;
    logic       w_hitY;
    logic [7:0] r_bounceCount;

    // A reflection is a bounce-mode move that flipped the overridden direction
    assign w_hitX = !r_manual && (w_axisX.dir != effDir(r_dirX, r_btnLeft, r_btnRight));
    assign w_hitY = !r_manual && (w_axisY.dir != effDir(r_dirY, r_btnUp, r_btnDown));

    // Hold the X reflection until both axes are known
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        r_hitX <= 1'b0;
        else if (w_moveX) r_hitX <= w_hitX;
    end

    // Add this frame's reflections (0..2) at MOVE_Y, wrapping mod 256
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        r_bounceCount <= 8'd0;
        else if (w_moveY) r_bounceCount <= r_bounceCount + 8'(r_hitX) + 8'(w_hitY);
    end

    assign bus.bounce_count = r_bounceCount;
`else
    assign bus.bounce_count = 8'd0;
`endif

    assign bus.logo_left   = r_left;
    assign bus.logo_top    = r_top;
    assign bus.manual_mode = r_manual;
    assign bus.update_done = r_done;

endmodule
